// File: rtl/riscv_pkg.sv
// Shared encodings for the hazard scoreboard and its forwarding selectors.
//   RES_LOAD : ResultSrc value that marks a load in E (data only ready after M)
//   FWD_*    : forwarding mux selects driven onto ForwardAE / ForwardBE
package riscv_pkg;

    localparam logic [1:0] RES_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from write-back stage
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from memory stage

endpackage

// File: rtl/forward_select.sv
// Forwarding select for one E-stage source operand.
//   Rs        : E-stage source register
//   RdM, RegWriteM : memory-stage destination and write enable
//   RdW, RegWriteW : write-back-stage destination and write enable
//   Forward   : FWD_M / FWD_W / FWD_RF
// The younger producer (M) wins over W; x0 is never forwarded.
module forward_select
    import riscv_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] Rs,
    input  logic [RAW-1:0] RdM,
    input  logic           RegWriteM,
    input  logic [RAW-1:0] RdW,
    input  logic           RegWriteW,
    output logic [1:0]     Forward
);

    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM == Rs) && (RdM != '0))
            Forward = FWD_M;
        else if (RegWriteW && (RdW == Rs) && (RdW != '0))
            Forward = FWD_W;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline with a register scoreboard for one
// variable-latency multi-cycle (mul/div) unit.
//   clk, rst          : clock, synchronous active-low reset
//   D-stage           : Rs1D/Rs2D (+UseRs1D/UseRs2D), RdD, McOpD
//   E-stage           : Rs1E/Rs2E/RdE, RegWriteE, ResultSrcE, PCSrcE, McIssueE
//   M-stage           : RdM, RegWriteM, MemAccessM, MemReadyM
//   W-stage           : RdW, RegWriteW
//   MC unit           : McDone in; McAck, McRd, McBusy out
//   Pipeline control  : StallF/D/E/M, FlushD/E/W, ForwardAE/BE
//   StallCount        : saturating count of cycles with StallD=1
// Control outputs are combinational; scoreboard state updates on posedge.
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int RAW    = 5,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAW-1:0]    Rs1D,
    input  logic [RAW-1:0]    Rs2D,
    input  logic              UseRs1D,
    input  logic              UseRs2D,
    input  logic [RAW-1:0]    RdD,
    input  logic              McOpD,
    input  logic [RAW-1:0]    Rs1E,
    input  logic [RAW-1:0]    Rs2E,
    input  logic [RAW-1:0]    RdE,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              McIssueE,
    input  logic [RAW-1:0]    RdM,
    input  logic              RegWriteM,
    input  logic              MemAccessM,
    input  logic              MemReadyM,
    input  logic [RAW-1:0]    RdW,
    input  logic              RegWriteW,
    input  logic              McDone,
    output logic              McAck,
    output logic [RAW-1:0]    McRd,
    output logic              McBusy,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [PERF_W-1:0] StallCount
);

    logic [NREGS-1:0]  pend;
    logic              busy;
    logic [RAW-1:0]    mcRd;
    logic [PERF_W-1:0] stallCnt;

    logic memWait, loadUse, rawSb, waw, structHz, hzD, issue;

    assign memWait  = MemAccessM & ~MemReadyM;
    assign loadUse  = (ResultSrcE == RES_LOAD) & RegWriteE & (RdE != '0) &
                      ((UseRs1D & (Rs1D == RdE)) | (UseRs2D & (Rs2D == RdE)));
    assign rawSb    = (pend[Rs1D] & UseRs1D) | (pend[Rs2D] & UseRs2D);
    assign waw      = pend[RdD] & (RdD != '0);
    // A second MC op may not enter E while the unit is busy or about to be.
    assign structHz = McOpD & (busy | McIssueE);
    assign hzD      = loadUse | rawSb | waw | structHz;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
        McAck  = 1'b0;
        if (rst) begin
            if (memWait) begin
                // Whole pipe freezes; a branch in E is held and resolves later.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = hzD;
                StallD = hzD;
                FlushD = PCSrcE;
                FlushE = PCSrcE | hzD;
                FlushW = 1'b0;
            end
            // Pipeline write-back owns the regfile port; MC waits its turn.
            McAck = McDone & busy & ~RegWriteW & ~memWait;
        end
    end

    assign issue = rst & McIssueE & ~StallE & ~busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend     <= '0;
            busy     <= 1'b0;
            mcRd     <= '0;
            stallCnt <= '0;
        end else begin
            // issue needs !busy and McAck needs busy, so they never coincide.
            if (issue) begin
                busy <= 1'b1;
                mcRd <= RdE;
                if (RdE != '0)
                    pend[RdE] <= 1'b1;
            end
            if (McAck) begin
                busy       <= 1'b0;
                pend[mcRd] <= 1'b0;
            end
            if (StallD && (stallCnt != {PERF_W{1'b1}}))
                stallCnt <= stallCnt + PERF_W'(1);
        end
    end

    assign McRd       = mcRd;
    assign McBusy     = busy;
    assign StallCount = stallCnt;

    logic [1:0][RAW-1:0] rsE;
    logic [1:0][1:0]     fwd;
    assign rsE = {Rs2E, Rs1E};

    for (genvar s = 0; s < 2; s++) begin : gFwd
        forward_select #(.RAW(RAW)) uFwd (
            .Rs        (rsE[s]),
            .RdM       (RdM),
            .RegWriteM (RegWriteM),
            .RdW       (RdW),
            .RegWriteW (RegWriteW),
            .Forward   (fwd[s])
        );
    end

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table for the combinational
// stall/flush/forward decode, plus hand-written multi-cycle sequences for
// the scoreboard, write-back arbitration, reset and counter saturation.
// A second instance with PERF_W=2 shares all inputs to show saturation.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       UseRs1D, UseRs2D, McOpD, RegWriteE, PCSrcE, McIssueE;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, MemAccessM, MemReadyM, RegWriteW, McDone;

    logic        McAck, McBusy, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [4:0]  McRd;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    logic        McAck2, McBusy2, StallF2, StallD2, StallE2, StallM2, FlushD2, FlushE2, FlushW2;
    logic [4:0]  McRd2;
    logic [1:0]  ForwardAE2, ForwardBE2;
    logic [1:0]  StallCount2;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREGS(32), .RAW(5), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
        .RdD(RdD), .McOpD(McOpD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McIssueE(McIssueE), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .RdW(RdW),
        .RegWriteW(RegWriteW), .McDone(McDone), .McAck(McAck), .McRd(McRd), .McBusy(McBusy),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD),
        .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount)
    );

    hazard_scoreboard #(.NREGS(32), .RAW(5), .PERF_W(2)) dutSat (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
        .RdD(RdD), .McOpD(McOpD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McIssueE(McIssueE), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .RdW(RdW),
        .RegWriteW(RegWriteW), .McDone(McDone), .McAck(McAck2), .McRd(McRd2), .McBusy(McBusy2),
        .StallF(StallF2), .StallD(StallD2), .StallE(StallE2), .StallM(StallM2), .FlushD(FlushD2),
        .FlushE(FlushE2), .FlushW(FlushW2), .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2),
        .StallCount(StallCount2)
    );

    // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE}
    logic [10:0] outVec;
    assign outVec = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; UseRs1D = 0; UseRs2D = 0; RdD = 0; McOpD = 0;
        Rs1E = 0; Rs2E = 0; RdE = 0; RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0; McIssueE = 0;
        RdM = 0; RegWriteM = 0; MemAccessM = 0; MemReadyM = 1; RdW = 0; RegWriteW = 0;
        McDone = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        clr();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [4:0]  rs1D, rs2D;
        logic        u1, u2;
        logic [4:0]  rs1E, rs2E, rdE;
        logic        rwE;
        logic [1:0]  resE;
        logic        pc;
        logic [4:0]  rdM;
        logic        rwM, memAcc, memRdy;
        logic [4:0]  rdW;
        logic        rwW;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // name, rs1D rs2D u1 u2, rs1E rs2E rdE rwE resE pc, rdM rwM memAcc memRdy, rdW rwW, expected
        vecs[0]  = '{"idle",          1, 2, 1, 1, 1, 2, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 11'b0000_000_00_00};
        vecs[1]  = '{"loaduse_a",     5, 2, 1, 1, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 11'b1100_010_00_00};
        vecs[2]  = '{"loaduse_unused",5, 2, 0, 1, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 11'b0000_000_00_00};
        vecs[3]  = '{"loaduse_x0",    0, 0, 1, 1, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 11'b0000_000_00_00};
        vecs[4]  = '{"loaduse_b",     1, 5, 1, 1, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 11'b1100_010_00_00};
        vecs[5]  = '{"alu_no_stall",  5, 2, 1, 1, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 11'b0000_000_00_00};
        vecs[6]  = '{"load_nowrite",  5, 2, 1, 1, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0, 11'b0000_000_00_00};
        vecs[7]  = '{"branch",        1, 2, 1, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 1, 0, 0, 11'b0000_110_00_00};
        vecs[8]  = '{"memwait_branch",1, 2, 1, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0, 0, 11'b1111_001_00_00};
        vecs[9]  = '{"memwait_ldu",   5, 2, 1, 1, 0, 0, 5, 1, 2'b01, 0, 0, 0, 1, 0, 0, 0, 11'b1111_001_00_00};
        vecs[10] = '{"fwd_m_over_w",  0, 0, 0, 0, 3, 4, 0, 0, 2'b00, 0, 3, 1, 0, 1, 3, 1, 11'b0000_000_10_00};
        vecs[11] = '{"fwd_x0",        0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 1, 11'b0000_000_00_00};
        vecs[12] = '{"fwd_w",         0, 0, 0, 0, 9, 9, 0, 0, 2'b00, 0, 9, 0, 0, 1, 9, 1, 11'b0000_000_01_01};
        vecs[13] = '{"fwd_mixed",     0, 0, 0, 0, 4, 6, 0, 0, 2'b00, 0, 6, 1, 0, 1, 4, 1, 11'b0000_000_01_10};
        vecs[14] = '{"branch_ldu",    5, 2, 1, 1, 0, 0, 5, 1, 2'b01, 1, 0, 0, 0, 1, 0, 0, 11'b1100_110_00_00};
        vecs[15] = '{"memready_br",   1, 2, 1, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 1, 0, 0, 11'b0000_110_00_00};

        // Reset: hazards and McDone presented, but everything must read as reset.
        clr();
        rst = 1'b0;
        MemAccessM = 1; MemReadyM = 0; McDone = 1;
        ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs1D = 5; UseRs1D = 1;
        @(negedge clk);
        chk("rst_vec", 32'(outVec), 32'(11'b0000_111_00_00));
        chk("rst_ack", 32'(McAck), 0);
        chk("rst_busy", 32'(McBusy), 0);
        chk("rst_mcrd", 32'(McRd), 0);
        chk("rst_cnt", 32'(StallCount), 0);
        rst = 1'b1;

        // Combinational decode table (scoreboard idle).
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            clr();
            Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; UseRs1D = vecs[i].u1; UseRs2D = vecs[i].u2;
            Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E; RdE = vecs[i].rdE; RegWriteE = vecs[i].rwE;
            ResultSrcE = vecs[i].resE; PCSrcE = vecs[i].pc; RdM = vecs[i].rdM;
            RegWriteM = vecs[i].rwM; MemAccessM = vecs[i].memAcc; MemReadyM = vecs[i].memRdy;
            RdW = vecs[i].rdW; RegWriteW = vecs[i].rwW;
            #1 chk(vecs[i].name, 32'(outVec), 32'(vecs[i].exp));
        end

        // Load-use: one stall cycle, then the consumer forwards from W.
        doReset();
        ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs1D = 5; UseRs1D = 1;
        #1 chk("lu_stall", 32'({StallF, StallD, FlushE}), 32'(3'b111));
        @(negedge clk);
        chk("lu_cnt", 32'(StallCount), 1);
        clr(); RdM = 5; RegWriteM = 1; ResultSrcE = 2'b00; Rs1D = 5; UseRs1D = 1;
        #1 chk("lu_release", 32'(StallD), 0);
        @(negedge clk);
        clr(); Rs1E = 5; RdW = 5; RegWriteW = 1;
        #1 chk("lu_fwd_w", 32'(ForwardAE), 32'(2'b01));

        // MC issue to x7, RAW/WAW/structural stalls, W-port arbitration.
        @(negedge clk);
        clr(); McIssueE = 1; RdE = 7; RegWriteE = 1; Rs1D = 1; UseRs1D = 1;
        #1 chk("mc_issue_nostall", 32'({StallE, McBusy}), 0);
        @(negedge clk);
        chk("mc_busy", 32'(McBusy), 1);
        chk("mc_rd", 32'(McRd), 7);
        clr(); Rs1D = 7; UseRs1D = 1;
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("mc_raw_%0d", k), 32'(StallD), 1);
            @(negedge clk);
        end
        clr(); RdD = 7;
        #1 chk("mc_waw", 32'(StallD), 1);
        @(negedge clk);
        clr(); McOpD = 1;
        #1 chk("mc_struct", 32'(StallD), 1);
        @(negedge clk);
        clr(); Rs1D = 7; UseRs1D = 1; McDone = 1; RegWriteW = 1; RdW = 3;
        for (int k = 0; k < 2; k++) begin
            #1 chk($sformatf("mc_wport_busy_%0d", k), 32'({McAck, StallD}), 32'(2'b01));
            @(negedge clk);
        end
        RegWriteW = 0; MemAccessM = 1; MemReadyM = 0;
        #1 chk("mc_ack_memwait", 32'(McAck), 0);
        @(negedge clk);
        MemAccessM = 0; MemReadyM = 1;
        #1 chk("mc_ack", 32'({McAck, StallD}), 32'(2'b11));
        @(negedge clk);
        McDone = 0;
        #1 chk("mc_done_release", 32'({McBusy, StallD}), 0);
        chk("mc_cnt", 32'(StallCount), 13);
        McDone = 1;
        #1 chk("mc_spurious_done", 32'(McAck), 0);
        @(negedge clk);
        chk("mc_spurious_idle", 32'(McBusy), 0);

        // Reset while busy drops the outstanding op and its pending bit.
        clr(); McIssueE = 1; RdE = 9; RegWriteE = 1;
        @(negedge clk);
        clr(); Rs1D = 9; UseRs1D = 1;
        #1 chk("raw_x9", 32'(StallD), 1);
        rst = 1'b0;
        #1 chk("rst_mid_vec", 32'(outVec), 32'(11'b0000_111_00_00));
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mid_busy", 32'(McBusy), 0);
        chk("rst_mid_cnt", 32'(StallCount), 0);
        #1 chk("rst_mid_pend", 32'(StallD), 0);

        // Issue to x0: unit busy, but no register becomes pending.
        @(negedge clk);
        clr(); McIssueE = 1; RdE = 0; RegWriteE = 1;
        @(negedge clk);
        chk("x0_busy", 32'({McBusy, McRd}), 32'(6'b1_00000));
        clr(); Rs1D = 0; Rs2D = 0; UseRs1D = 1; UseRs2D = 1; RdD = 0;
        #1 chk("x0_nopend", 32'(StallD), 0);
        @(negedge clk);
        clr(); McOpD = 1;
        #1 chk("x0_struct", 32'(StallD), 1);
        @(negedge clk);
        clr(); McDone = 1;
        #1 chk("x0_ack", 32'(McAck), 1);
        @(negedge clk);
        clr();
        chk("x0_idle", 32'(McBusy), 0);

        // Counter saturation on the PERF_W=2 instance.
        doReset();
        ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs1D = 5; UseRs1D = 1;
        repeat (3) @(negedge clk);
        chk("cnt3_wide", 32'(StallCount), 3);
        chk("cnt3_narrow", 32'(StallCount2), 3);
        repeat (2) @(negedge clk);
        chk("cnt5_wide", 32'(StallCount), 5);
        chk("cnt_sat_narrow", 32'(StallCount2), 3);
        clr();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
